// File: rtl/ps2_link_pkg.sv
// Shared constants, state encodings and the key-event payload for the PS/2 link layer.
package ps2_link_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_WAIT_ACK,
    T_GAP
  } tx_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  localparam int unsigned EVENT_W = $bits(key_event_t);

  // Decoder state that carries the given {ext, brk} prefix flags.
  function automatic dec_state_e dec_state_of(input logic ext, input logic brk);
    case ({ext, brk})
      2'b10:   return D_EXT;
      2'b01:   return D_BRK;
      2'b11:   return D_EXT_BRK;
      default: return D_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO with exact occupancy count and full/empty flags.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ps2_keyboard_link.sv
// PS/2 link layer: scan-code decoder feeding an event FIFO, and a host command
// transmitter with ACK/resend handling, bounded retries and ACK timeout.
module ps2_keyboard_link
  import ps2_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       ctl_command,
  output logic             ctl_send,
  input  logic             ctl_sent,
  input  logic             ctl_timeout,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             cmd_done,
  output logic             cmd_error,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic [7:0]       last_byte
);

  localparam int unsigned TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  dec_state_e         dec_state_q, dec_state_d;
  tx_state_e          tx_state_q, tx_state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               done_d, error_d, fail;
  logic               ctl_send_q, cmd_ready_q, cmd_done_q, cmd_error_q;
  logic [7:0]         last_byte_q;
  logic               overflow_q, overflow_d;

  logic               rx_ack, rx_resend, rx_owned;
  logic               cur_ext, cur_brk;
  logic               ev_push, ev_pop;
  key_event_t         ev_in, ev_out;
  logic [EVENT_W-1:0] fifo_rd;
  logic               fifo_full, fifo_empty;

  assign rx_ack    = rx_valid && (rx_data == PS2_ACK);
  assign rx_resend = rx_valid && (rx_data == PS2_RESEND);
  // FA/FE belong to the transmitter only while it is waiting for a reply.
  assign rx_owned  = (tx_state_q == T_WAIT_ACK) && (rx_ack || rx_resend);

  assign cur_ext = (dec_state_q == D_EXT) || (dec_state_q == D_EXT_BRK);
  assign cur_brk = (dec_state_q == D_BRK) || (dec_state_q == D_EXT_BRK);

  // Scan-code decoder: prefixes accumulate flags, any other byte emits an event.
  always_comb begin
    dec_state_d = dec_state_q;
    ev_push     = 1'b0;
    ev_in.code  = rx_data;
    ev_in.ext   = cur_ext;
    ev_in.brk   = cur_brk;
    if (rx_valid && !rx_owned) begin
      if (rx_data == PS2_EXT) begin
        dec_state_d = dec_state_of(1'b1, cur_brk);
      end else if (rx_data == PS2_BRK) begin
        dec_state_d = dec_state_of(cur_ext, 1'b1);
      end else begin
        ev_push     = 1'b1;
        dec_state_d = D_IDLE;
      end
    end
  end

  assign ev_pop     = ev_ready & ~fifo_empty;
  assign overflow_d = overflow_q | (ev_push & fifo_full & ~ev_pop);

  ps2_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_event_fifo (
    .clk         (CLOCK_50),
    .rst_n       (reset_n),
    .push_i      (ev_push),
    .push_data_i (EVENT_W'(ev_in)),
    .pop_i       (ev_ready),
    .pop_data_o  (fifo_rd),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign ev_out   = key_event_t'(fifo_rd);
  assign ev_code  = ev_out.code;
  assign ev_ext   = ev_out.ext;
  assign ev_break = ev_out.brk;
  assign ev_valid = ~fifo_empty;

  // Transmit FSM next-state; a failed attempt either retries via T_GAP or reports error.
  always_comb begin
    tx_state_d = tx_state_q;
    cmd_d      = cmd_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    fail       = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (cmd_valid) begin
          cmd_d      = cmd_data;
          retry_d    = '0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (ctl_sent) begin
          timer_d    = '0;
          tx_state_d = T_WAIT_ACK;
        end else if (ctl_timeout) begin
          fail = 1'b1;
        end
      end
      T_WAIT_ACK: begin
        timer_d = timer_q + TIMER_W'(1);
        if (rx_ack) begin
          done_d     = 1'b1;
          tx_state_d = T_IDLE;
        end else if (rx_resend || (timer_q == TIMER_W'(ACK_TIMEOUT - 1))) begin
          fail = 1'b1;
        end
      end
      T_GAP: begin
        tx_state_d = T_SEND;
      end
      default: begin
        tx_state_d = T_IDLE;
      end
    endcase
    if (fail) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d    = retry_q + RETRY_W'(1);
        tx_state_d = T_GAP;
      end else begin
        error_d    = 1'b1;
        tx_state_d = T_IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dec_state_q <= D_IDLE;
      tx_state_q  <= T_IDLE;
      cmd_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      ctl_send_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      last_byte_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      dec_state_q <= dec_state_d;
      tx_state_q  <= tx_state_d;
      cmd_q       <= cmd_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      ctl_send_q  <= (tx_state_d == T_SEND);
      cmd_ready_q <= (tx_state_d == T_IDLE);
      cmd_done_q  <= done_d;
      cmd_error_q <= error_d;
      overflow_q  <= overflow_d;
      if (rx_valid) last_byte_q <= rx_data;
    end
  end

  assign ctl_command = cmd_q;
  assign ctl_send    = ctl_send_q;
  assign cmd_ready   = cmd_ready_q;
  assign cmd_done    = cmd_done_q;
  assign cmd_error   = cmd_error_q;
  assign last_byte   = last_byte_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_link.sv
// Scoreboard bench for ps2_keyboard_link: decoder events, FIFO overflow, command ACK/retry/timeout, reset.
module tb_ps2_keyboard_link;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned MAX_RETRY   = 2;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic [7:0]       ctl_command;
  logic             ctl_send;
  logic             ctl_sent = 1'b0;
  logic             ctl_timeout = 1'b0;
  logic [7:0]       cmd_data = '0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready, cmd_done, cmd_error;
  logic [7:0]       ev_code;
  logic             ev_ext, ev_break, ev_valid;
  logic             ev_ready = 1'b0;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       last_byte;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [9:0] sb [$];

  ps2_keyboard_link #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MAX_RETRY   (MAX_RETRY),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .ctl_command (ctl_command),
    .ctl_send    (ctl_send),
    .ctl_sent    (ctl_sent),
    .ctl_timeout (ctl_timeout),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .cmd_error   (cmd_error),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .last_byte   (last_byte)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_done === 1'b1)  done_cnt++;
    if (cmd_error === 1'b1) err_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic accept_cmd(input logic [7:0] b);
    check("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic sent_pulse();
    ctl_sent = 1'b1;
    tick();
    ctl_sent = 1'b0;
  endtask

  // Pop every queued event and compare it with the scoreboard head.
  task automatic drain(input string tag);
    logic [9:0] exp;
    int guard;
    guard = 0;
    ev_ready = 1'b1;
    while (ev_valid === 1'b1 && guard < 16) begin
      if (sb.size() == 0) begin
        check({tag, "_unexpected"}, 32'(ev_valid), 32'd0);
      end else begin
        exp = sb.pop_front();
        check({tag, "_ev"}, 32'({ev_code, ev_ext, ev_break}), 32'(exp));
      end
      tick();
      guard++;
    end
    ev_ready = 1'b0;
    check({tag, "_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_cnt0"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    logic [9:0] exp;
    int d0, e0, n;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", 32'({ctl_send, cmd_done, cmd_error, ev_valid, overflow}), 32'd0);
    check("rst_bytes", 32'({ctl_command, last_byte, ev_code}), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Make code
    send_rx(8'h1C);
    sb.push_back({8'h1C, 1'b0, 1'b0});
    check("make_valid", 32'(ev_valid), 32'd1);
    check("make_event", 32'({ev_code, ev_ext, ev_break}), 32'({8'h1C, 1'b0, 1'b0}));
    check("make_last", 32'(last_byte), 32'h1C);
    drain("make");

    // Prefix combinations
    send_rx(8'hE0); send_rx(8'hF0); send_rx(8'h75); sb.push_back({8'h75, 1'b1, 1'b1});
    send_rx(8'hF0); send_rx(8'hE0); send_rx(8'h75); sb.push_back({8'h75, 1'b1, 1'b1});
    send_rx(8'hE0); send_rx(8'hE0); send_rx(8'h12); sb.push_back({8'h12, 1'b1, 1'b0});
    send_rx(8'hF0); send_rx(8'h1C); sb.push_back({8'h1C, 1'b0, 1'b1});
    check("prefix_count", 32'(fifo_count), 32'd4);
    check("prefix_no_ovf", 32'(overflow), 32'd0);
    drain("prefix");

    // FA/FE outside a command are plain codes
    send_rx(8'hFA); sb.push_back({8'hFA, 1'b0, 1'b0});
    send_rx(8'hE1); sb.push_back({8'hE1, 1'b0, 1'b0});
    send_rx(8'hF0); send_rx(8'hFE); sb.push_back({8'hFE, 1'b0, 1'b1});
    check("plain_last", 32'(last_byte), 32'hFE);
    drain("plain");

    // Overflow at full, then simultaneous push and pop
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i * 8'h11));
      if (i <= 4) sb.push_back({8'(i * 8'h11), 1'b0, 1'b0});
    end
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    exp = sb.pop_front();
    check("ovf_head", 32'({ev_code, ev_ext, ev_break}), 32'(exp));
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    sb.push_back({8'h66, 1'b0, 1'b0});
    tick();
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    check("full_pushpop_count", 32'(fifo_count), 32'd4);
    check("full_pushpop_ovf", 32'(overflow), 32'd1);
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Command acknowledged; decoder state survives the owned FA
    accept_cmd(8'hED);
    check("ack_command", 32'(ctl_command), 32'hED);
    check("ack_send", 32'(ctl_send), 32'd1);
    check("ack_busy", 32'(cmd_ready), 32'd0);
    repeat (2) tick();
    check("ack_send_hold", 32'(ctl_send), 32'd1);
    sent_pulse();
    check("ack_send_low", 32'(ctl_send), 32'd0);
    send_rx(8'hE0);
    d0 = done_cnt;
    send_rx(8'hFA);
    check("ack_done", 32'(cmd_done), 32'd1);
    check("ack_ready", 32'(cmd_ready), 32'd1);
    check("ack_no_event", 32'(fifo_count), 32'd0);
    tick();
    check("ack_done_pulse", 32'(cmd_done), 32'd0);
    check("ack_done_once", 32'(done_cnt - d0), 32'd1);
    send_rx(8'h5A); sb.push_back({8'h5A, 1'b1, 1'b0});
    drain("ack");

    // Resend three times, then error
    e0 = err_cnt;
    accept_cmd(8'hF3);
    for (int a = 0; a <= int'(MAX_RETRY); a++) begin
      check("fe_send_hi", 32'(ctl_send), 32'd1);
      check("fe_command", 32'(ctl_command), 32'hF3);
      sent_pulse();
      check("fe_wait_low", 32'(ctl_send), 32'd0);
      send_rx(8'hFE);
      if (a < int'(MAX_RETRY)) begin
        check("fe_gap_low", 32'({ctl_send, cmd_error}), 32'd0);
        tick();
      end else begin
        check("fe_error", 32'(cmd_error), 32'd1);
        check("fe_ready", 32'(cmd_ready), 32'd1);
      end
    end
    check("fe_no_event", 32'(fifo_count), 32'd0);
    tick();
    check("fe_error_once", 32'(err_cnt - e0), 32'd1);

    // No response: error after MAX_RETRY+1 timeouts
    e0 = err_cnt;
    accept_cmd(8'hF4);
    for (int a = 0; a <= int'(MAX_RETRY); a++) begin
      check("to_send_hi", 32'(ctl_send), 32'd1);
      sent_pulse();
      n = 0;
      while (ctl_send !== 1'b1 && cmd_error !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("to_cycles", 32'(n), (a < int'(MAX_RETRY)) ? ACK_TIMEOUT + 1 : ACK_TIMEOUT);
    end
    check("to_error", 32'(cmd_error), 32'd1);
    tick();
    check("to_error_once", 32'(err_cnt - e0), 32'd1);

    // Controller timeout retries; FA at the timer's last cycle still wins
    accept_cmd(8'hF5);
    ctl_timeout = 1'b1;
    tick();
    ctl_timeout = 1'b0;
    check("ctlto_gap", 32'(ctl_send), 32'd0);
    tick();
    check("ctlto_resend", 32'(ctl_send), 32'd1);
    sent_pulse();
    repeat (ACK_TIMEOUT - 1) tick();
    send_rx(8'hFA);
    check("fa_wins_done", 32'(cmd_done), 32'd1);
    check("fa_wins_err", 32'(cmd_error), 32'd0);
    tick();

    // Reset in T_WAIT_ACK with events queued
    send_rx(8'h31);
    send_rx(8'h32);
    check("rst_mid_count", 32'(fifo_count), 32'd2);
    accept_cmd(8'hF6);
    sent_pulse();
    d0 = done_cnt;
    e0 = err_cnt;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("rst_mid_cnt0", 32'(fifo_count), 32'd0);
    check("rst_mid_valid", 32'(ev_valid), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_send", 32'(ctl_send), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst_mid_pulses", 32'({done_cnt - d0, err_cnt - e0} != 0), 32'd0);
    check("rst_mid_clear", 32'({overflow, last_byte, ctl_command}), 32'd0);
    check("rst_mid_idle", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_link.md
Name: ps2_keyboard_link

Overview:
- Parametrised PS/2 link layer between the byte-level PS2_Controller and user logic.
- Receive path: decodes raw scan-code bytes (E0 extended prefix, F0 break prefix) into key events and buffers them in a FIFO with valid/ready handshake.
- Transmit path: accepts host command bytes, drives the controller's send interface, waits for keyboard ACK (FA) or resend (FE), and retries up to a bounded count.
- Also holds the last received byte for the HEX display.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
- MAX_RETRY, 3, retransmissions after the first attempt before reporting an error.
- ACK_TIMEOUT, 1000000, CLOCK_50 cycles to wait for FA/FE after the controller reports the byte sent (20 ms).
- CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
- CLOCK_50  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  PS2_Controller received_data.
- rx_valid  in  1  PS2_Controller received_data_en; one-cycle strobe.
- ctl_command  out  8  to PS2_Controller the_command.
- ctl_send  out  1  to PS2_Controller send_command.
- ctl_sent  in  1  PS2_Controller command_was_sent.
- ctl_timeout  in  1  PS2_Controller error_communication_timed_out.
- cmd_data  in  8  host command byte.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  transmit path idle; cmd_data accepted when cmd_valid & cmd_ready.
- cmd_done  out  1  one-cycle pulse: command acknowledged (FA).
- cmd_error  out  1  one-cycle pulse: retries exhausted.
- ev_code  out  8  event scan code.
- ev_ext  out  1  event had E0 prefix.
- ev_break  out  1  event had F0 prefix (key release).
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready.
- fifo_count  out  CNT_W  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped; cleared only by reset.
- last_byte  out  8  last rx byte of any kind.

Behaviour:
- Reset (async assert, sync deassert recommended):
  - All outputs 0, except cmd_ready = 1.
  - FIFO empty, decoder in D_IDLE, transmit FSM in T_IDLE, retry counter and timer cleared.
  - Reset mid-transmission or mid-sequence abandons it silently; no done/error pulse.
- last_byte:
  - Loads rx_data on every rx_valid, including FA/FE.
- Decoder states D_IDLE, D_EXT, D_BRK, D_EXT_BRK; flags held as {ext, brk}:
  - E0 sets ext; F0 sets brk. Both prefixes may appear in either order.
  - Any other byte pushes {code, ext, brk} to the FIFO and returns to D_IDLE.
  - A repeated prefix is idempotent.
  - E1, AA, EE and other non-prefix bytes are plain codes with the current flags.
- Ownership of FA/FE:
  - While the transmit FSM is in T_WAIT_ACK, FA and FE are consumed by the transmit FSM: not decoded, not pushed, decoder state unchanged.
  - In any other state, FA and FE are decoded as plain codes.
- FIFO (first-word fall-through):
  - A pushed event appears on ev_* with ev_valid = 1 on the cycle after the push strobe.
  - Pop takes effect at the clock edge; the next entry is presented in the same cycle.
  - Full, with push and pop in the same cycle: both occur; count unchanged; no overflow.
  - Full, push without pop: event dropped, overflow set.
  - Empty: a pop attempt is ignored (ev_valid = 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact in the range 0..FIFO_DEPTH.
- Transmit FSM:
  - T_IDLE: cmd_ready = 1. On accept, latch cmd_data into ctl_command, retry = 0, go to T_SEND.
  - T_SEND: ctl_send = 1.
    - ctl_sent: go to T_WAIT_ACK, timer = 0.
    - ctl_timeout: treat as a failed attempt.
  - T_WAIT_ACK: timer increments each cycle.
    - FA: cmd_done pulse, go to T_IDLE.
    - FE, or timer reaching ACK_TIMEOUT-1: failed attempt.
  - Failed attempt, retry < MAX_RETRY: retry++, go to T_GAP.
  - Failed attempt, retry = MAX_RETRY: cmd_error pulse, go to T_IDLE.
  - T_GAP: ctl_send = 0 for exactly one cycle, then T_SEND.
  - ctl_command stays stable from accept until return to T_IDLE.
  - Simultaneous rx FA and timer expiry: FA wins.
- Total attempts per command: MAX_RETRY+1.

Decomposition:
- Package ps2_link_pkg:
  - byte constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE;
  - decoder and transmit state enums;
  - event struct {code[7:0], ext, brk}.
- Sub-module ps2_event_fifo: generic FWFT FIFO (width, depth parameters), with count and full/empty flags.
- Decoder and transmit FSM stay in the top module.

Test Plan:
- Make code: rx 1C -> one event {1C, ext 0, brk 0}; ev_valid = 1 one cycle after the strobe; last_byte = 1C.
- Extended release: rx E0, F0, 75 -> single event {75, 1, 1}. Separately, rx F0, E0, 75 gives the same event.
- Overflow: FIFO_DEPTH = 4, ev_ready = 0, push 5 codes -> fifo_count = 4, overflow = 1, events 1-4 retained in order. Then push while popping at full -> count stays 4, overflow remains set from before.
- Command ACK: cmd ED accepted -> ctl_command = ED, ctl_send high until ctl_sent; rx FA -> cmd_done pulse, cmd_ready = 1, no event queued.
- Retry then error: MAX_RETRY = 2, respond FE three times -> three ctl_send assertions separated by a one-cycle low, then cmd_error pulse. Repeat with no response and ACK_TIMEOUT = 16 -> error after 3 timeouts.
- Reset mid-operation: assert reset_n low during T_WAIT_ACK with 2 events queued -> immediately fifo_count = 0, ev_valid = 0, cmd_ready = 1, no done/error pulse.
